regfile_writeback_scheduler: RTL and testbench

- Sequences writebacks from the even and odd SPU pipes into the single write port of the 128x128-bit register file (RT address, 128-bit data, write enable).
- Buffers each pipe's results in a small per-lane queue and retires them strictly in acceptance order.
- Exports a per-register pending mask that issue logic uses for RAW/WAW stalls.

---
 rtl/regfile_writeback_scheduler_if.sv | 30 +++
 rtl/regfile_writeback_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_regfile_writeback_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_scheduler_if.sv
// Writeback bundle between the SPU pipes, the scheduler and the register-file write port.
interface regfile_writeback_scheduler_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 128
);
  logic              evenValid;
  logic              evenReady;
  logic [ADDR_W-1:0] evenRT;
  logic [DATA_W-1:0] evenData;
  logic              oddValid;
  logic              oddReady;
  logic [ADDR_W-1:0] oddRT;
  logic [DATA_W-1:0] oddData;
  logic              regWriteEnable;
  logic [ADDR_W-1:0] writeRegisterRT;
  logic [DATA_W-1:0] writeData;
  logic [127:0]      pendingMask;

  // Producer side: pipes drive requests and observe the write port.
  modport master (
    output evenValid, evenRT, evenData, oddValid, oddRT, oddData,
    input  evenReady, oddReady, regWriteEnable, writeRegisterRT, writeData, pendingMask
  );

  // Scheduler side.
  modport slave (
    input  evenValid, evenRT, evenData, oddValid, oddRT, oddData,
    output evenReady, oddReady, regWriteEnable, writeRegisterRT, writeData, pendingMask
  );
endinterface

// File: rtl/regfile_writeback_scheduler.sv
// Writeback scheduler: per-lane FIFOs for the even/odd SPU pipes, an order queue that
// retires entries in acceptance order through the single register-file write port, and
// a per-register pending mask for issue stalls.
// Optional feature macro: WB_BYPASS_EN (single accept on an empty scheduler goes straight
// to the write-port registers).
module regfile_writeback_scheduler #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  regfile_writeback_scheduler_if.slave bus
);
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned OrdPtrW  = PtrW + 1;
  localparam int unsigned OrdCntW  = PtrW + 2;
  localparam int unsigned OrdDepth = 2 * DEPTH;
  localparam int unsigned NumRegs  = 128;
  localparam logic [CntW-1:0] LaneFull = CntW'(DEPTH);

  // Lane storage, index 0 = even, 1 = odd
  logic [ADDR_W-1:0]  rt_q     [2][DEPTH];
  logic [ADDR_W-1:0]  rt_d     [2][DEPTH];
  logic [DATA_W-1:0]  data_q   [2][DEPTH];
  logic [DATA_W-1:0]  data_d   [2][DEPTH];
  logic [PtrW-1:0]    wr_ptr_q [2];
  logic [PtrW-1:0]    wr_ptr_d [2];
  logic [PtrW-1:0]    rd_ptr_q [2];
  logic [PtrW-1:0]    rd_ptr_d [2];
  logic [CntW-1:0]    cnt_q    [2];
  logic [CntW-1:0]    cnt_d    [2];

  // Order queue holds the lane ID of each accepted entry
  logic               ord_q    [OrdDepth];
  logic               ord_d    [OrdDepth];
  logic [OrdPtrW-1:0] ord_wr_q, ord_wr_d;
  logic [OrdPtrW-1:0] ord_rd_q, ord_rd_d;
  logic [OrdCntW-1:0] ord_cnt_q, ord_cnt_d;
  logic [OrdPtrW-1:0] ord_idx;

  // Write-port registers
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  wrt_q, wrt_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [1:0]         lane_valid, lane_ready, lane_acc, lane_push, lane_pop, lane_byp;
  logic [ADDR_W-1:0]  lane_rt   [2];
  logic [DATA_W-1:0]  lane_data [2];
  logic               ord_empty;
  logic               pop_lane;
  logic [PtrW-1:0]    slot_off;
  logic [NumRegs-1:0] pending;

  assign lane_valid   = {bus.oddValid, bus.evenValid};
  assign lane_rt[0]   = bus.evenRT;
  assign lane_rt[1]   = bus.oddRT;
  assign lane_data[0] = bus.evenData;
  assign lane_data[1] = bus.oddData;

  // Ready from registered count only, forced low while reset is held
  always_comb begin
    lane_ready = 2'b00;
    for (int l = 0; l < 2; l++) begin
      lane_ready[l] = reset && (cnt_q[l] < LaneFull);
    end
  end

  // Accept, pop and bypass decisions for this cycle
  always_comb begin
    lane_acc  = lane_valid & lane_ready;
    ord_empty = (ord_cnt_q == '0);
    pop_lane  = ord_q[ord_rd_q];
    lane_pop  = 2'b00;
    if (!ord_empty) lane_pop[pop_lane] = 1'b1;
    lane_byp  = 2'b00;
`ifdef WB_BYPASS_EN
    // Empty order queue implies empty lanes and an idle port next cycle; even wins a tie
    if (ord_empty) begin
      if (lane_acc[0])      lane_byp[0] = 1'b1;
      else if (lane_acc[1]) lane_byp[1] = 1'b1;
    end
`endif
    lane_push = lane_acc & ~lane_byp;
  end

  // Lane FIFO next state: push at write pointer, pop advances read pointer
  always_comb begin
    rt_d   = rt_q;
    data_d = data_q;
    for (int l = 0; l < 2; l++) begin
      wr_ptr_d[l] = wr_ptr_q[l] + PtrW'(lane_push[l]);
      rd_ptr_d[l] = rd_ptr_q[l] + PtrW'(lane_pop[l]);
      cnt_d[l]    = cnt_q[l] + CntW'(lane_push[l]) - CntW'(lane_pop[l]);
      if (lane_push[l]) begin
        rt_d[l][wr_ptr_q[l]]   = lane_rt[l];
        data_d[l][wr_ptr_q[l]] = lane_data[l];
      end
    end
  end

  // Order queue next state: even recorded ahead of odd on a simultaneous accept
  always_comb begin
    ord_d   = ord_q;
    ord_idx = ord_wr_q;
    if (lane_push[0]) begin
      ord_d[ord_idx] = 1'b0;
      ord_idx        = ord_idx + OrdPtrW'(1);
    end
    if (lane_push[1]) begin
      ord_d[ord_idx] = 1'b1;
      ord_idx        = ord_idx + OrdPtrW'(1);
    end
    ord_wr_d  = ord_idx;
    ord_rd_d  = ord_rd_q + OrdPtrW'(!ord_empty);
    ord_cnt_d = ord_cnt_q + OrdCntW'(lane_push[0]) + OrdCntW'(lane_push[1])
              - OrdCntW'(!ord_empty);
  end

  // Write-port next state: address/data hold when nothing retires
  always_comb begin
    we_d    = 1'b0;
    wrt_d   = wrt_q;
    wdata_d = wdata_q;
    if (!ord_empty) begin
      we_d    = 1'b1;
      wrt_d   = rt_q[pop_lane][rd_ptr_q[pop_lane]];
      wdata_d = data_q[pop_lane][rd_ptr_q[pop_lane]];
    end else if (lane_byp[0]) begin
      we_d    = 1'b1;
      wrt_d   = lane_rt[0];
      wdata_d = lane_data[0];
    end else if (lane_byp[1]) begin
      we_d    = 1'b1;
      wrt_d   = lane_rt[1];
      wdata_d = lane_data[1];
    end
  end

  // Pending mask over valid lane entries plus the write port
  always_comb begin
    pending  = '0;
    slot_off = '0;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_off = PtrW'(i) - rd_ptr_q[l];
        if (CntW'(slot_off) < cnt_q[l]) pending[rt_q[l][i]] = 1'b1;
      end
    end
    if (we_q) pending[wrt_q] = 1'b1;
  end

  // Control state with synchronous active-low reset; queued writes are discarded
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '{default: '0};
      rd_ptr_q  <= '{default: '0};
      cnt_q     <= '{default: '0};
      ord_wr_q  <= '0;
      ord_rd_q  <= '0;
      ord_cnt_q <= '0;
      we_q      <= 1'b0;
      wrt_q     <= '0;
      wdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ord_wr_q  <= ord_wr_d;
      ord_rd_q  <= ord_rd_d;
      ord_cnt_q <= ord_cnt_d;
      we_q      <= we_d;
      wrt_q     <= wrt_d;
      wdata_q   <= wdata_d;
    end
  end

  // Queue payload storage; validity is tracked by the pointers and counts
  always_ff @(posedge clk) begin
    rt_q   <= rt_d;
    data_q <= data_d;
    ord_q  <= ord_d;
  end

  assign bus.evenReady       = lane_ready[0];
  assign bus.oddReady        = lane_ready[1];
  assign bus.regWriteEnable  = we_q;
  assign bus.writeRegisterRT = wrt_q;
  assign bus.writeData       = wdata_q;
  assign bus.pendingMask     = pending;
endmodule

// File: tb/tb_regfile_writeback_scheduler.sv
// Directed bench for regfile_writeback_scheduler; expectations follow WB_BYPASS_EN.
module tb_regfile_writeback_scheduler;
  localparam int unsigned Depth = 2;
`ifdef WB_BYPASS_EN
  localparam logic Byp = 1'b1;
`else
  localparam logic Byp = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]   rt;
    logic [127:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  wr_t  mon_q[$];
  int   mon_cyc[$];
  wr_t  exp_q[$];
  logic [127:0] rf [128];
  int   ei, oi, odd_low_cyc;

  regfile_writeback_scheduler_if #(.ADDR_W(7), .DATA_W(128)) bus ();

  regfile_writeback_scheduler #(
    .DEPTH  (Depth),
    .ADDR_W (7),
    .DATA_W (128)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Register-file model: record every write committed at a posedge
  always @(posedge clk) begin
    if (bus.regWriteEnable === 1'b1) begin
      mon_q.push_back({bus.writeRegisterRT, bus.writeData});
      mon_cyc.push_back(cyc);
      rf[bus.writeRegisterRT] = bus.writeData;
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic wr_t mon_at(input int i);
    return (i < mon_q.size()) ? mon_q[i] : '0;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < mon_cyc.size()) ? mon_cyc[i] : -100;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.evenValid = 1'b0;
    bus.evenRT    = '0;
    bus.evenData  = '0;
    bus.oddValid  = 1'b0;
    bus.oddRT     = '0;
    bus.oddData   = '0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (10) step();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    step();
    step();
    check_eq("rst_we", bus.regWriteEnable, 0);
    check_eq("rst_rt", bus.writeRegisterRT, 0);
    check_eq("rst_data", bus.writeData, 0);
    check_eq("rst_pend", bus.pendingMask, 0);
    check_eq("rst_even_rdy", bus.evenReady, 0);
    check_eq("rst_odd_rdy", bus.oddReady, 0);
    reset = 1'b1;
    #1;
    check_eq("post_rst_even_rdy", bus.evenReady, 1);
    check_eq("post_rst_odd_rdy", bus.oddReady, 1);

    // Single lane: RT=5, data=54
    bus.evenValid = 1'b1;
    bus.evenRT    = 7'd5;
    bus.evenData  = 128'd54;
    step();
    idle_inputs();
    check_eq("single_we_e1", bus.regWriteEnable, Byp);
    check_eq("single_pend_e1", bus.pendingMask, 128'd1 << 5);
    step();
    check_eq("single_we_e2", bus.regWriteEnable, !Byp);
    check_eq("single_rt_e2", bus.writeRegisterRT, 5);
    check_eq("single_data_e2", bus.writeData, 54);
    check_eq("single_pend_e2", bus.pendingMask, Byp ? 128'd0 : (128'd1 << 5));
    step();
    check_eq("single_we_e3", bus.regWriteEnable, 0);
    check_eq("single_pend_e3", bus.pendingMask, 0);
    drain();

    // Simultaneous accept to the same register: odd value must win
    mon_q.delete();
    mon_cyc.delete();
    bus.evenValid = 1'b1; bus.evenRT = 7'd10; bus.evenData = 128'hA;
    bus.oddValid  = 1'b1; bus.oddRT  = 7'd10; bus.oddData  = 128'hB;
    step();
    drain();
    check_eq("simul_count", mon_q.size(), 2);
    check_eq("simul_rt0", mon_at(0).rt, 10);
    check_eq("simul_d0", mon_at(0).d, 128'hA);
    check_eq("simul_rt1", mon_at(1).rt, 10);
    check_eq("simul_d1", mon_at(1).d, 128'hB);
    check_eq("simul_consec", cyc_at(1) - cyc_at(0), 1);
    check_eq("simul_rf10", rf[10], 128'hB);

    // Interleaved order: even 1 + odd 2, then even 3
    mon_q.delete();
    mon_cyc.delete();
    bus.evenValid = 1'b1; bus.evenRT = 7'd1; bus.evenData = 128'h11;
    bus.oddValid  = 1'b1; bus.oddRT  = 7'd2; bus.oddData  = 128'h22;
    step();
    bus.oddValid  = 1'b0;
    bus.evenRT = 7'd3; bus.evenData = 128'h33;
    step();
    drain();
    check_eq("intl_count", mon_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("intl_rt%0d", i), mon_at(i).rt, 7'(i + 1));
      check_eq($sformatf("intl_d%0d", i), mon_at(i).d, 128'(8'h11 * (i + 1)));
    end
    check_eq("intl_consec01", cyc_at(1) - cyc_at(0), 1);
    check_eq("intl_consec12", cyc_at(2) - cyc_at(1), 1);
    check_eq("intl_pend_done", bus.pendingMask, 0);

    // Backpressure: both lanes held with a proper valid/ready producer
    mon_q.delete();
    mon_cyc.delete();
    exp_q.delete();
    ei = 0;
    oi = 0;
    odd_low_cyc = 0;
    for (int c = 1; c <= 20 && (ei < 4 || oi < 4); c++) begin
      bus.evenValid = (ei < 4);
      bus.evenRT    = 7'(30 + ei);
      bus.evenData  = 128'(32'h100 + ei);
      bus.oddValid  = (oi < 4);
      bus.oddRT     = 7'(40 + oi);
      bus.oddData   = 128'(32'h200 + oi);
      if (bus.evenValid && bus.evenReady) begin
        exp_q.push_back({bus.evenRT, bus.evenData});
        ei++;
      end
      if (bus.oddValid && bus.oddReady) begin
        exp_q.push_back({bus.oddRT, bus.oddData});
        oi++;
      end
      step();
      if (odd_low_cyc == 0 && bus.oddReady == 1'b0) odd_low_cyc = c;
    end
    drain();
    check_eq("bp_even_accepted", ei, 4);
    check_eq("bp_odd_accepted", oi, 4);
    check_eq("bp_odd_stall_cycle", odd_low_cyc, Byp ? 3 : 2);
    check_eq("bp_retire_count", mon_q.size(), 8);
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("bp_rt%0d", i), mon_at(i).rt, exp_q[i].rt);
      check_eq($sformatf("bp_d%0d", i), mon_at(i).d, exp_q[i].d);
    end
    check_eq("bp_pend_done", bus.pendingMask, 0);

    // Reset flush with writes in flight
    bus.evenValid = 1'b1; bus.evenRT = 7'd20; bus.evenData = 128'h1;
    bus.oddValid  = 1'b1; bus.oddRT  = 7'd21; bus.oddData  = 128'h2;
    step();
    bus.oddValid  = 1'b0;
    bus.evenRT = 7'd22; bus.evenData = 128'h3;
    step();
    idle_inputs();
    check_eq("flush_pend_before", bus.pendingMask != 0, 1);
    reset = 1'b0;
    step();
    check_eq("flush_we", bus.regWriteEnable, 0);
    check_eq("flush_pend", bus.pendingMask, 0);
    check_eq("flush_even_rdy", bus.evenReady, 0);
    check_eq("flush_odd_rdy", bus.oddReady, 0);
    mon_q.delete();
    mon_cyc.delete();
    reset = 1'b1;
    #1;
    check_eq("flush_even_rdy_after", bus.evenReady, 1);
    check_eq("flush_odd_rdy_after", bus.oddReady, 1);
    repeat (6) step();
    check_eq("flush_no_writes", mon_q.size(), 0);
    check_eq("flush_pend_after", bus.pendingMask, 0);

    // Bypass latency: RT=7 on an empty scheduler
    bus.evenValid = 1'b1;
    bus.evenRT    = 7'd7;
    bus.evenData  = 128'h77;
    step();
    idle_inputs();
    check_eq("byp_we_e1", bus.regWriteEnable, Byp);
    check_eq("byp_rt_e1", bus.writeRegisterRT, Byp ? 7'd7 : 7'd0);
    step();
    check_eq("byp_we_e2", bus.regWriteEnable, !Byp);
    check_eq("byp_rt_e2", bus.writeRegisterRT, 7);
    check_eq("byp_data_e2", bus.writeData, 128'h77);
    drain();
    check_eq("byp_rf7", rf[7], 128'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
